minipit_host_loader: RTL and testbench

Host-side writer that programs the minipit timer over its byte-wide register-write port and tracks the interrupts the timer raises. It accepts one load command (16-bit divisor plus 8-bit mode config) on a valid/ready handshake. The command is serialised into a fixed sequence of register writes with setup, strobe and gap timing. It also edge-counts the timer's interrupt output. It sits between a host controller or test sequencer and the minipit core on the same clock.

---
 rtl/minipit_host_loader.sv | 171 +++++++++++++++++
 tb/tb_minipit_host_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/minipit_host_loader.sv
// Host-side loader for the minipit timer: serialises one divisor/config command into
// byte-wide register writes with setup/strobe/gap timing, and counts timer interrupt edges.
module minipit_host_loader #(
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_divisor,
  input  logic [7:0]  cmd_config,
  output logic        load_done,
  output logic [1:0]  pit_addr,
  output logic [7:0]  pit_data,
  output logic        pit_we,
  input  logic        pit_busy,
  input  logic        pit_irq,
  input  logic        irq_clear,
  output logic [7:0]  irq_count,
  output logic        irq_pending
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [1:0] LAST_IDX    = AUTO_START ? 2'd3 : 2'd2;
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST    = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [3:0]  tmr_q;
  logic [15:0] div_q;
  logic [7:0]  cfg_q;
  logic        ready_q;
  logic        done_q;
  logic [1:0]  addr_q;
  logic [7:0]  data_q;
  logic        we_q;

  logic [1:0]  next_idx;
  logic [7:0]  next_data;

  assign next_idx = idx_q + 2'd1;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_data = 8'h01;
    case (next_idx)
      2'd0:    next_data = cfg_q;
      2'd1:    next_data = div_q[7:0];
      2'd2:    next_data = div_q[15:8];
      default: next_data = 8'h01;
    endcase
  end

  // NOTE: the reset is asynchronous so pit_we drops at once, and all state uses non-blocking updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      tmr_q   <= 4'd0;
      div_q   <= 16'd0;
      cfg_q   <= 8'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      addr_q  <= 2'd0;
      data_q  <= 8'd0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && ready_q) begin
            div_q   <= cmd_divisor;
            cfg_q   <= cmd_config;
            idx_q   <= 2'd0;
            addr_q  <= 2'd0;
            data_q  <= cmd_config;
            ready_q <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!pit_busy) begin
            we_q    <= 1'b1;
            tmr_q   <= STROBE_LAST;
            state_q <= S_STROBE;
          end
        end
        S_STROBE, S_GAP: begin
          if (tmr_q != 4'd0) begin
            tmr_q <= tmr_q - 4'd1;
          end else if (state_q == S_STROBE && GAP_CYCLES != 0) begin
            we_q    <= 1'b0;
            tmr_q   <= GAP_LAST;
            state_q <= S_GAP;
          end else begin
            // End of this write's timing window: either finish or set up the next register.
            we_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= next_idx;
              addr_q  <= next_idx;
              data_q  <= next_data;
              state_q <= S_SETUP;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign load_done = done_q;
  assign pit_addr  = addr_q;
  assign pit_data  = data_q;
  assign pit_we    = we_q;

  logic       irq_prev_q;
  logic       irq_rise;
  logic [7:0] irq_count_q;
  logic [7:0] irq_count_d;
  logic       irq_pending_q;

  // A clear that coincides with a new edge keeps that edge, so the count restarts at 1.
  always_comb begin
    irq_rise    = pit_irq && !irq_prev_q;
    irq_count_d = irq_count_q;
    if (irq_clear) begin
      irq_count_d = {7'd0, irq_rise};
    end else if (irq_rise && irq_count_q != 8'hFF) begin
      irq_count_d = irq_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q    <= 1'b0;
      irq_count_q   <= 8'd0;
      irq_pending_q <= 1'b0;
    end else begin
      irq_prev_q    <= pit_irq;
      irq_count_q   <= irq_count_d;
      irq_pending_q <= (irq_count_d != 8'd0);
    end
  end

  assign irq_count   = irq_count_q;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_minipit_host_loader.sv
// Self-checking bench: directed vector tables plus randomized commands and interrupt traffic
// compared against a timeline model of the write sequence and an edge-counting model.
module tb_minipit_host_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        cmd_valid;
  logic [15:0] cmd_divisor;
  logic [7:0]  cmd_config;
  logic        pit_busy;
  logic        pit_irq;
  logic        irq_clear;

  logic        valid_a, valid_b;
  logic        ready_a, ready_b, done_a, done_b, we_a, we_b, pend_a, pend_b;
  logic [1:0]  addr_a, addr_b;
  logic [7:0]  data_a, data_b, cnt_a, cnt_b;

  assign valid_a = cmd_valid && !sel;
  assign valid_b = cmd_valid && sel;

  minipit_host_loader u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_divisor(cmd_divisor), .cmd_config(cmd_config), .load_done(done_a),
    .pit_addr(addr_a), .pit_data(data_a), .pit_we(we_a), .pit_busy(pit_busy),
    .pit_irq(pit_irq), .irq_clear(irq_clear), .irq_count(cnt_a), .irq_pending(pend_a)
  );

  minipit_host_loader #(.STROBE_CYCLES(3), .GAP_CYCLES(0), .AUTO_START(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_divisor(cmd_divisor), .cmd_config(cmd_config), .load_done(done_b),
    .pit_addr(addr_b), .pit_data(data_b), .pit_we(we_b), .pit_busy(pit_busy),
    .pit_irq(pit_irq), .irq_clear(irq_clear), .irq_count(cnt_b), .irq_pending(pend_b)
  );

  logic       m_ready, m_done, m_we;
  logic [1:0] m_addr;
  logic [7:0] m_data;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_we    = sel ? we_b    : we_a;
  assign m_addr  = sel ? addr_b  : addr_a;
  assign m_data  = sel ? data_b  : data_a;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: busy pattern indexed by cycle after the accepting edge.
  logic busy_pat [0:255];
  int   strobe_at [4];
  int   done_cyc;

  function automatic logic [7:0] payload(input int i, input logic [15:0] d, input logic [7:0] c);
    case (i)
      0:       return c;
      1:       return d[7:0];
      2:       return d[15:8];
      default: return 8'h01;
    endcase
  endfunction

  task automatic plan(input int s_cyc, input int g_cyc, input int nw);
    int s = 0;
    int e;
    for (int w = 0; w < nw; w++) begin
      e = s + 1;
      while (busy_pat[e-1] && e < 250) e++;
      strobe_at[w] = e;
      s = e + s_cyc + g_cyc;
    end
    done_cyc = s;
  endtask

  task automatic clear_busy();
    for (int i = 0; i < 256; i++) busy_pat[i] = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input bit use_b, input logic [15:0] div,
                         input logic [7:0] cfg, output int obs_done);
    int          s_cyc, g_cyc, nw, idx;
    logic        we_e;
    logic [12:0] exp_v;
    s_cyc    = use_b ? 3 : 1;
    g_cyc    = use_b ? 0 : 2;
    nw       = use_b ? 3 : 4;
    obs_done = -1;
    @(negedge clk);
    sel         = use_b;
    cmd_divisor = div;
    cmd_config  = cfg;
    pit_busy    = 1'b0;
    cmd_valid   = 1'b1;
    #1 check({tag, "_ready_pre"}, m_ready, 1);
    plan(s_cyc, g_cyc, nw);
    @(posedge clk);
    for (int k = 0; k <= done_cyc + 1; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      idx  = 0;
      we_e = 1'b0;
      for (int w = 0; w < nw; w++) begin
        if (w > 0 && k >= strobe_at[w-1] + s_cyc + g_cyc) idx = w;
        if (k >= strobe_at[w] && k < strobe_at[w] + s_cyc) we_e = 1'b1;
      end
      exp_v = {we_e, 2'(idx), payload(idx, div, cfg), 1'(k == done_cyc), 1'(k > done_cyc)};
      check($sformatf("%s_cyc%0d{we,addr,data,done,ready}", tag, k),
            {m_we, m_addr, m_data, m_done, m_ready}, exp_v);
      if (m_done === 1'b1 && obs_done < 0) obs_done = k;
      pit_busy = (k < 256) ? busy_pat[k] : 1'b0;
      if (k <= done_cyc) @(posedge clk);
    end
    pit_busy = 1'b0;
  endtask

  typedef struct {
    bit          use_b;
    logic [15:0] div;
    logic [7:0]  cfg;
    int          busy_from;
    int          busy_len;
    int          exp_done;
  } cmd_vec_t;

  typedef struct {
    logic       irq;
    logic       clr;
    logic [7:0] count;
    logic       pending;
  } irq_vec_t;

  initial begin
    cmd_vec_t cmd_tbl [4];
    irq_vec_t irq_tbl [9];
    int       obs;
    int       mcount;
    logic     mprev;
    logic     rise;

    cmd_tbl[0] = '{1'b0, 16'hA55A, 8'h03, 0, 0, 16};
    cmd_tbl[1] = '{1'b0, 16'hA55A, 8'h03, 4, 5, 21};
    cmd_tbl[2] = '{1'b1, 16'hBEEF, 8'h81, 0, 0, 12};
    cmd_tbl[3] = '{1'b1, 16'h1234, 8'h7E, 0, 2, 14};

    irq_tbl[0] = '{1'b1, 1'b1, 8'd1, 1'b1};
    irq_tbl[1] = '{1'b1, 1'b0, 8'd1, 1'b1};
    irq_tbl[2] = '{1'b0, 1'b0, 8'd1, 1'b1};
    irq_tbl[3] = '{1'b0, 1'b1, 8'd0, 1'b0};
    irq_tbl[4] = '{1'b1, 1'b0, 8'd1, 1'b1};
    irq_tbl[5] = '{1'b0, 1'b0, 8'd1, 1'b1};
    irq_tbl[6] = '{1'b1, 1'b0, 8'd2, 1'b1};
    irq_tbl[7] = '{1'b1, 1'b1, 8'd0, 1'b0};
    irq_tbl[8] = '{1'b0, 1'b0, 8'd0, 1'b0};

    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_divisor = '0; cmd_config = '0;
    pit_busy = 1'b0; pit_irq = 1'b0; irq_clear = 1'b0;
    clear_busy();

    #12;
    check("reset_ready", ready_a, 1);
    check("reset_we_done", {we_a, done_a}, 0);
    check("reset_addr_data", {addr_a, data_a}, 0);
    check("reset_irq", {cnt_a, pend_a}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      clear_busy();
      for (int j = 0; j < cmd_tbl[i].busy_len; j++) busy_pat[cmd_tbl[i].busy_from + j] = 1'b1;
      run_cmd($sformatf("vec%0d", i), cmd_tbl[i].use_b, cmd_tbl[i].div, cmd_tbl[i].cfg, obs);
      check($sformatf("vec%0d_done_cycle", i), obs, cmd_tbl[i].exp_done);
    end

    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 256; j++) busy_pat[j] = (j < 150) ? ($urandom_range(2) == 0) : 1'b0;
      run_cmd($sformatf("rnd%0d", i), 1'(i % 2), 16'($urandom), 8'($urandom), obs);
    end
    clear_busy();

    // cmd_valid held high: one acceptance per IDLE visit.
    @(negedge clk);
    sel = 1'b0; cmd_divisor = 16'h5A5A; cmd_config = 8'h11; cmd_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      check($sformatf("hold_cyc%0d{ready,done}", k), {ready_a, done_a},
            {1'(k == 17 || k == 35), 1'(k == 16 || k == 34)});
      if (k == 35) cmd_valid = 1'b0;
      else @(posedge clk);
    end
    @(negedge clk);
    check("hold_idle_after", {ready_a, we_a}, 2'b10);

    // Reset asserted during the third strobe.
    sel = 1'b0; cmd_divisor = 16'h1234; cmd_config = 8'h44; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_third_strobe{we,addr,data}", {we_a, addr_a, data_a}, {1'b1, 2'd2, 8'h12});
    rst = 1'b1;
    #1;
    check("rst_mid{we,ready,done}", {we_a, ready_a, done_a}, 3'b010);
    check("rst_mid_addr_data", {addr_a, data_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_cmd("post_rst", 1'b0, 16'h0001, 8'h05, obs);
    check("post_rst_done_cycle", obs, 16);

    // Interrupt saturation.
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      pit_irq = 1'b1;
      @(negedge clk);
      pit_irq = 1'b0;
      if (i == 0 || i == 254 || i == 259)
        check($sformatf("irq_sat_%0d", i), {cnt_a, pend_a}, {8'((i + 1 > 255) ? 255 : i + 1), 1'b1});
    end
    @(negedge clk);
    check("irq_sat_final", {cnt_a, pend_a}, {8'd255, 1'b1});

    for (int i = 0; i < 9; i++) begin
      pit_irq   = irq_tbl[i].irq;
      irq_clear = irq_tbl[i].clr;
      @(negedge clk);
      check($sformatf("irq_vec%0d{count,pending}", i), {cnt_a, pend_a},
            {irq_tbl[i].count, irq_tbl[i].pending});
    end

    mcount = 0;
    mprev  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      pit_irq   = 1'($urandom_range(1));
      irq_clear = ($urandom_range(7) == 0);
      rise = pit_irq && !mprev;
      if (irq_clear) mcount = rise ? 1 : 0;
      else if (rise && mcount < 255) mcount++;
      mprev = pit_irq;
      @(negedge clk);
      check($sformatf("irq_rnd%0d_a", i), {cnt_a, pend_a}, {8'(mcount), 1'(mcount != 0)});
      check($sformatf("irq_rnd%0d_b", i), {cnt_b, pend_b}, {8'(mcount), 1'(mcount != 0)});
    end
    pit_irq = 1'b0;
    irq_clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
